uart_cmd_master: RTL and testbench

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

---
 rtl/uart_cmd_pkg.sv | 31 +++
 rtl/uart_cmd_timeout.sv | 36 +++
 rtl/uart_cmd_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_cmd_master.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command master.
// Holds the command opcodes, the single-byte response codes and the
// controller state encoding used by uart_cmd_master.
package uart_cmd_pkg;

    // Command opcodes (first byte of every command)
    localparam logic [7:0] OP_REG_WR = 8'h57;  // 'W' idx D3 D2 D1 D0
    localparam logic [7:0] OP_REG_RD = 8'h52;  // 'R' idx
    localparam logic [7:0] OP_MEM_WR = 8'h4D;  // 'M' A1 A0 D3 D2 D1 D0
    localparam logic [7:0] OP_MEM_RD = 8'h6D;  // 'm' A1 A0

    // Single-byte responses
    localparam logic [7:0] RSP_ACK = 8'h4B;    // 'K' write accepted
    localparam logic [7:0] RSP_ERR = 8'h3F;    // '?' bad opcode or index

    typedef enum logic [2:0] {
        StIdle,
        StGetIdx,
        StGetAddr,
        StGetData,
        StExec,
        StMemWait,
        StSend
    } state_t;

    // True when the opcode carries a 4-byte data payload.
    function automatic logic op_has_data(input logic [7:0] op);
        return (op == OP_REG_WR) || (op == OP_MEM_WR);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout for the command parser.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - reload the counter (a byte was accepted)
//   run       - parser is waiting for the next byte of a command
//   expire    - TIMEOUT_CYCLES idle cycles have already elapsed and this
//               cycle is idle too; the command must be abandoned
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= RELOAD;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // A byte arriving in the same cycle always wins over expiry.
    assign expire = run && !load && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_master.sv
// Byte-stream command master: parses commands arriving as UART bytes,
// writes two design registers or a 512-word remote memory, reads back a
// result register or memory word, and streams responses out.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   rx_byte, rx_valid            - received byte with one-cycle strobe
//   tx_byte, tx_valid, tx_ready  - response byte stream (valid/ready)
//   in, in_valid_pulse           - register 0 data and write strobe
//   select, select_valid_pulse   - register 1 data and write strobe
//   result                       - design output register read by idx 0
//   remote_mem_addr/wdata/wr     - memory address, write data, write strobe
//   remote_mem_rdata             - memory read data (MEM_RD_LATENCY cycles)
//   cmd_err                      - one-cycle pulse on any protocol error
module uart_cmd_master
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MEM_RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] in,
    output logic        in_valid_pulse,
    output logic [31:0] select,
    output logic        select_valid_pulse,
    input  logic [31:0] result,
    output logic [8:0]  remote_mem_addr,
    output logic [31:0] remote_mem_wdata,
    output logic        remote_mem_wr,
    input  logic [31:0] remote_mem_rdata,
    output logic        cmd_err
);

    localparam int unsigned WW = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_RD_LATENCY > 0) ? MEM_RD_LATENCY - 1 : 0);

    state_t        state;
    logic [7:0]    opcode;
    logic [7:0]    idx;
    logic [31:0]   data_sr;   // payload collected MSB first
    logic [31:0]   resp_sr;   // remaining response bytes, next one in [31:24]
    logic [1:0]    byte_cnt;
    logic [1:0]    resp_cnt;  // bytes still to send after the current tx_byte
    logic [WW-1:0] wait_cnt;

    logic        in_get;
    logic        rx_accept;
    logic        expire;
    logic [31:0] word_next;

    assign in_get    = (state == StGetIdx) || (state == StGetAddr) || (state == StGetData);
    assign rx_accept = rx_valid && ((state == StIdle) || in_get);
    assign word_next = {data_sr[23:0], rx_byte};

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (rx_accept),
        .run    (in_get),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= StIdle;
            opcode             <= '0;
            idx                <= '0;
            data_sr            <= '0;
            resp_sr            <= '0;
            byte_cnt           <= '0;
            resp_cnt           <= '0;
            wait_cnt           <= '0;
            tx_byte            <= '0;
            tx_valid           <= 1'b0;
            in                 <= '0;
            in_valid_pulse     <= 1'b0;
            select             <= '0;
            select_valid_pulse <= 1'b0;
            remote_mem_addr    <= '0;
            remote_mem_wdata   <= '0;
            remote_mem_wr      <= 1'b0;
            cmd_err            <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            in_valid_pulse     <= 1'b0;
            select_valid_pulse <= 1'b0;
            remote_mem_wr      <= 1'b0;
            cmd_err            <= 1'b0;

            case (state)
                StIdle: begin
                    if (rx_valid) begin
                        opcode   <= rx_byte;
                        byte_cnt <= '0;
                        case (rx_byte)
                            OP_REG_WR, OP_REG_RD: state <= StGetIdx;
                            OP_MEM_WR, OP_MEM_RD: state <= StGetAddr;
                            default: begin
                                cmd_err  <= 1'b1;
                                tx_byte  <= RSP_ERR;
                                tx_valid <= 1'b1;
                                resp_cnt <= '0;
                                state    <= StSend;
                            end
                        endcase
                    end
                end

                StGetIdx: begin
                    if (expire) begin
                        cmd_err <= 1'b1;
                        state   <= StIdle;
                    end else if (rx_valid) begin
                        idx      <= rx_byte;
                        byte_cnt <= '0;
                        state    <= op_has_data(opcode) ? StGetData : StExec;
                    end
                end

                StGetAddr: begin
                    // Only address bits [8:0] are kept; the memory has 512 words.
                    if (expire) begin
                        cmd_err <= 1'b1;
                        state   <= StIdle;
                    end else if (rx_valid) begin
                        if (byte_cnt == 2'd0) begin
                            remote_mem_addr[8] <= rx_byte[0];
                            byte_cnt           <= 2'd1;
                        end else begin
                            remote_mem_addr[7:0] <= rx_byte;
                            byte_cnt             <= '0;
                            state                <= op_has_data(opcode) ? StGetData : StExec;
                        end
                    end
                end

                StGetData: begin
                    if (expire) begin
                        cmd_err <= 1'b1;
                        state   <= StIdle;
                    end else if (rx_valid) begin
                        data_sr  <= word_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Strobes land in the EXEC cycle that follows.
                            state <= StExec;
                            if (opcode == OP_MEM_WR) begin
                                remote_mem_wdata <= word_next;
                                remote_mem_wr    <= 1'b1;
                            end else if (idx == 8'd0) begin
                                in             <= word_next;
                                in_valid_pulse <= 1'b1;
                            end else if (idx == 8'd1) begin
                                select             <= word_next;
                                select_valid_pulse <= 1'b1;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                end

                StExec: begin
                    if (rx_valid) begin
                        cmd_err <= 1'b1;
                    end
                    case (opcode)
                        OP_REG_WR: begin
                            tx_byte  <= ((idx == 8'd0) || (idx == 8'd1)) ? RSP_ACK : RSP_ERR;
                            tx_valid <= 1'b1;
                            resp_cnt <= '0;
                            state    <= StSend;
                        end
                        OP_MEM_WR: begin
                            tx_byte  <= RSP_ACK;
                            tx_valid <= 1'b1;
                            resp_cnt <= '0;
                            state    <= StSend;
                        end
                        OP_REG_RD: begin
                            tx_valid <= 1'b1;
                            state    <= StSend;
                            if (idx == 8'd0) begin
                                tx_byte  <= result[31:24];
                                resp_sr  <= {result[23:0], 8'h00};
                                resp_cnt <= 2'd3;
                            end else begin
                                cmd_err  <= 1'b1;
                                tx_byte  <= RSP_ERR;
                                resp_cnt <= '0;
                            end
                        end
                        OP_MEM_RD: begin
                            wait_cnt <= '0;
                            state    <= StMemWait;
                        end
                        default: state <= StIdle;
                    endcase
                end

                StMemWait: begin
                    if (rx_valid) begin
                        cmd_err <= 1'b1;
                    end
                    if (wait_cnt == WAIT_LAST) begin
                        tx_byte  <= remote_mem_rdata[31:24];
                        resp_sr  <= {remote_mem_rdata[23:0], 8'h00};
                        resp_cnt <= 2'd3;
                        tx_valid <= 1'b1;
                        state    <= StSend;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end

                StSend: begin
                    if (rx_valid) begin
                        cmd_err <= 1'b1;
                    end
                    // tx_valid is always high here, so tx_ready alone completes a transfer.
                    if (tx_ready) begin
                        if (resp_cnt == 2'd0) begin
                            tx_valid <= 1'b0;
                            state    <= StIdle;
                        end else begin
                            tx_byte  <= resp_sr[31:24];
                            resp_sr  <= {resp_sr[23:0], 8'h00};
                            resp_cnt <= resp_cnt - 2'd1;
                        end
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
`timescale 1ns/1ps
module tb_uart_cmd_master;

    localparam int unsigned TO  = 40;
    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] in;
    logic        in_valid_pulse;
    logic [31:0] select;
    logic        select_valid_pulse;
    logic [31:0] result;
    logic [8:0]  remote_mem_addr;
    logic [31:0] remote_mem_wdata;
    logic        remote_mem_wr;
    logic [31:0] remote_mem_rdata;
    logic        cmd_err;

    uart_cmd_master #(
        .TIMEOUT_CYCLES(TO),
        .MEM_RD_LATENCY(LAT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_byte            (rx_byte),
        .rx_valid           (rx_valid),
        .tx_byte            (tx_byte),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .in                 (in),
        .in_valid_pulse     (in_valid_pulse),
        .select             (select),
        .select_valid_pulse (select_valid_pulse),
        .result             (result),
        .remote_mem_addr    (remote_mem_addr),
        .remote_mem_wdata   (remote_mem_wdata),
        .remote_mem_wr      (remote_mem_wr),
        .remote_mem_rdata   (remote_mem_rdata),
        .cmd_err            (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init_val(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010003);
    endfunction

    // Remote memory device: read data appears LAT cycles after the address.
    logic        mem_init;
    logic [31:0] dev_mem [512];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= dev_mem[remote_mem_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_init) begin
            for (int i = 0; i < 512; i++) dev_mem[i] <= mem_init_val(i);
        end else if (remote_mem_wr) begin
            dev_mem[remote_mem_addr] <= remote_mem_wdata;
        end
    end
    assign remote_mem_rdata = rd_pipe[LAT-1];

    // tx_ready pattern: 0 always high, 1 toggle, 2 random, 3 held low
    int ready_mode = 0;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ~tx_ready;
                2: tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Observation of DUT outputs on the falling edge
    int          in_cnt = 0, sel_cnt = 0, wr_cnt = 0, err_cnt = 0;
    int          multi_cnt = 0, stall_viol = 0;
    logic [31:0] wr_addr_last = '0, wr_data_last = '0;
    logic [7:0]  tx_q [$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (in_valid_pulse) in_cnt <= in_cnt + 1;
            if (select_valid_pulse) sel_cnt <= sel_cnt + 1;
            if (remote_mem_wr) begin
                wr_cnt       <= wr_cnt + 1;
                wr_addr_last <= 32'(remote_mem_addr);
                wr_data_last <= remote_mem_wdata;
            end
            if (cmd_err) err_cnt <= err_cnt + 1;
            if ((int'(in_valid_pulse) + int'(select_valid_pulse) + int'(remote_mem_wr)) > 1)
                multi_cnt <= multi_cnt + 1;
            if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
            if (prev_stall && (!tx_valid || (tx_byte != prev_byte)))
                stall_viol <= stall_viol + 1;
            prev_stall <= tx_valid && !tx_ready;
            prev_byte  <= tx_byte;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [512];
    logic [31:0] ref_in = '0, ref_sel = '0;
    int          exp_in_cnt = 0, exp_sel_cnt = 0, exp_wr_cnt = 0, exp_err = 0;
    logic [31:0] exp_wr_addr = '0, exp_wr_data = '0;
    logic [7:0]  exp_tx [$];
    logic [7:0]  cmd_q [$];
    int          tx_base = 0;

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
    endtask

    // Expected effect of the command in cmd_q, from the command rules.
    task automatic model_cmd();
        logic [31:0] d;
        logic [15:0] a16;
        int          ai;
        case (cmd_q[0])
            8'h57: begin
                d = {cmd_q[2], cmd_q[3], cmd_q[4], cmd_q[5]};
                if (cmd_q[1] == 8'd0) begin
                    exp_in_cnt++;
                    ref_in = d;
                    exp_tx.push_back(8'h4B);
                end else if (cmd_q[1] == 8'd1) begin
                    exp_sel_cnt++;
                    ref_sel = d;
                    exp_tx.push_back(8'h4B);
                end else begin
                    exp_err++;
                    exp_tx.push_back(8'h3F);
                end
            end
            8'h52: begin
                if (cmd_q[1] == 8'd0) begin
                    push_word(result);
                end else begin
                    exp_err++;
                    exp_tx.push_back(8'h3F);
                end
            end
            8'h4D: begin
                a16 = {cmd_q[1], cmd_q[2]};
                ai  = int'(a16) % 512;
                d   = {cmd_q[3], cmd_q[4], cmd_q[5], cmd_q[6]};
                ref_mem[ai] = d;
                exp_wr_cnt++;
                exp_wr_addr = 32'(ai);
                exp_wr_data = d;
                exp_tx.push_back(8'h4B);
            end
            8'h6D: begin
                a16 = {cmd_q[1], cmd_q[2]};
                ai  = int'(a16) % 512;
                push_word(ref_mem[ai]);
            end
            default: begin
                exp_err++;
                exp_tx.push_back(8'h3F);
            end
        endcase
    endtask

    // Called 1ns after a rising edge; leaves 1ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input int gmax);
        for (int i = 0; i < cmd_q.size(); i++) send_byte(cmd_q[i], $urandom_range(0, gmax));
    endtask

    task automatic finish_cmd(input string tag);
        int k;
        int got;
        k = 0;
        while (((tx_q.size() - tx_base) < exp_tx.size()) && (k < 2000)) begin
            @(posedge clk);
            k++;
        end
        if (k >= 2000) check({tag, "_tx_wait"}, 32'(tx_q.size() - tx_base), 32'(exp_tx.size()));
        repeat (4) @(posedge clk);
        #1;
        got = tx_q.size() - tx_base;
        check({tag, "_tx_count"}, 32'(got), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < got; i++)
            check($sformatf("%s_tx_byte%0d", tag, i), 32'(tx_q[tx_base + i]), 32'(exp_tx[i]));
        tx_base = tx_q.size();
        exp_tx.delete();
        check({tag, "_in_pulses"}, 32'(in_cnt), 32'(exp_in_cnt));
        check({tag, "_sel_pulses"}, 32'(sel_cnt), 32'(exp_sel_cnt));
        check({tag, "_mem_wr_pulses"}, 32'(wr_cnt), 32'(exp_wr_cnt));
        check({tag, "_cmd_err_pulses"}, 32'(err_cnt), 32'(exp_err));
        check({tag, "_in_value"}, in, ref_in);
        check({tag, "_select_value"}, select, ref_sel);
        check({tag, "_mem_wr_addr"}, wr_addr_last, exp_wr_addr);
        check({tag, "_mem_wr_data"}, wr_data_last, exp_wr_data);
        check({tag, "_multi_strobe"}, 32'(multi_cnt), 32'd0);
        check({tag, "_tx_hold"}, 32'(stall_viol), 32'd0);
    endtask

    task automatic run_cmd(input string tag, input int gmax);
        model_cmd();
        send_cmd(gmax);
        finish_cmd(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
        check({tag, "_in_pulse"}, 32'(in_valid_pulse), 32'd0);
        check({tag, "_sel_pulse"}, 32'(select_valid_pulse), 32'd0);
        check({tag, "_mem_wr"}, 32'(remote_mem_wr), 32'd0);
        check({tag, "_in"}, in, 32'd0);
        check({tag, "_select"}, select, 32'd0);
        check({tag, "_mem_addr"}, 32'(remote_mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, remote_mem_wdata, 32'd0);
        check({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
    endtask

    initial begin
        int          k;
        int          r;
        logic [7:0]  op;
        logic [31:0] w;

        rst      = 1'b1;
        mem_init = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = '0;
        result   = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = mem_init_val(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Register 0 write with strobe timing
        cmd_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2C};
        model_cmd();
        send_cmd(0);
        check("regwr_pulse_cycle", 32'(in_valid_pulse), 32'd1);
        check("regwr_in_value", in, 32'h0000012C);
        @(posedge clk);
        #1;
        check("regwr_pulse_after", 32'(in_valid_pulse), 32'd0);
        finish_cmd("regwr0");

        // Register read with tx_ready toggling
        ready_mode = 1;
        result     = 32'hDEADBEEF;
        cmd_q      = '{8'h52, 8'h00};
        run_cmd("regrd", 0);
        ready_mode = 0;

        // Memory write then read at the top address
        cmd_q = '{8'h4D, 8'h01, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78};
        run_cmd("memwr", 0);
        check("memwr_addr_1ff", wr_addr_last, 32'h1FF);
        cmd_q = '{8'h6D, 8'h01, 8'hFF};
        run_cmd("memrd", 0);

        // Bad opcode and bad register index
        cmd_q = '{8'hAA};
        run_cmd("badop", 0);
        cmd_q = '{8'h57, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
        run_cmd("badidx", 0);
        cmd_q = '{8'h52, 8'h07};
        run_cmd("badrdidx", 0);

        // Inter-byte timeout: expiry after TO+1 idle cycles, then a clean read
        exp_err++;
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, TO + 1);
        finish_cmd("timeout");
        result = 32'h13579BDF;
        cmd_q  = '{8'h52, 8'h00};
        run_cmd("after_timeout", 1);

        // Exactly TO idle cycles is still within one command
        cmd_q = '{8'h57, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        model_cmd();
        send_byte(cmd_q[0], 0);
        send_byte(cmd_q[1], TO);
        for (int i = 2; i < 6; i++) send_byte(cmd_q[i], 0);
        finish_cmd("gap_limit");

        // Byte arriving while the response is stalled is dropped
        ready_mode = 3;
        result     = 32'h0BADF00D;
        cmd_q      = '{8'h52, 8'h00};
        model_cmd();
        send_cmd(0);
        repeat (6) @(posedge clk);
        #1;
        check("stall_tx_valid", 32'(tx_valid), 32'd1);
        send_byte(8'h4D, 0);
        exp_err++;
        ready_mode = 0;
        finish_cmd("drop_in_send");

        // Randomized command mix
        for (int n = 0; n < 60; n++) begin
            ready_mode = $urandom_range(0, 2);
            result     = $urandom;
            cmd_q.delete();
            r = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0: begin
                    cmd_q.push_back(8'h57);
                    cmd_q.push_back((r < 2) ? 8'(r) : 8'($urandom_range(2, 255)));
                    for (int i = 0; i < 4; i++) cmd_q.push_back(8'($urandom));
                end
                1: begin
                    cmd_q.push_back(8'h52);
                    cmd_q.push_back((r < 3) ? 8'h00 : 8'($urandom_range(1, 255)));
                end
                2: begin
                    cmd_q.push_back(8'h4D);
                    for (int i = 0; i < 6; i++) cmd_q.push_back(8'($urandom));
                end
                3: begin
                    cmd_q.push_back(8'h6D);
                    if ((r < 2) && (exp_wr_cnt > 0)) begin
                        w = exp_wr_addr;
                        cmd_q.push_back({7'($urandom), w[8]});
                        cmd_q.push_back(w[7:0]);
                    end else begin
                        cmd_q.push_back(8'($urandom));
                        cmd_q.push_back(8'($urandom));
                    end
                end
                default: begin
                    op = 8'($urandom);
                    while ((op == 8'h57) || (op == 8'h52) || (op == 8'h4D) || (op == 8'h6D))
                        op = 8'($urandom);
                    cmd_q.push_back(op);
                end
            endcase
            run_cmd($sformatf("rand%0d", n), 3);
        end
        ready_mode = 0;

        // Reset after the second response byte
        result = 32'hA1B2C3D4;
        cmd_q  = '{8'h52, 8'h00};
        send_cmd(0);
        k = 0;
        while (((tx_q.size() - tx_base) < 2) && (k < 200)) begin
            @(posedge clk);
            k++;
        end
        if (k >= 200) check("rstsend_wait", 32'(tx_q.size() - tx_base), 32'd2);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rstsend");
        if ((tx_q.size() - tx_base) >= 2) begin
            check("rstsend_byte0", 32'(tx_q[tx_base]), 32'hA1);
            check("rstsend_byte1", 32'(tx_q[tx_base + 1]), 32'hB2);
        end
        tx_base = tx_base + 2;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        ref_in  = '0;
        ref_sel = '0;
        repeat (16) @(posedge clk);
        #1;
        finish_cmd("after_rst");
        cmd_q = '{8'h52, 8'h00};
        run_cmd("post_rst_rd", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
